// File: rtl/cc1200_rx_merge.sv
`default_nettype none
// ============================================================================
//  Module      : cc1200_rx_merge
//  Description : Merges four CC1200 receive channels into one stream. Each
//                channel tags its data with a latched address and queues it
//                in a small FIFO. A single register slice drains the FIFOs
//                in round-robin order. Optional macro RXM_OVF_CNT_EN adds
//                saturating 8-bit per-channel drop counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module cc1200_rx_merge #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [47:0] RxData,
    input  logic [3:0]  RxValid,
    input  logic [63:0] RxAdd,
    input  logic [3:0]  RxAddValid,
    input  logic [3:0]  Out_Off_Link,
    output logic [11:0] m_data,
    output logic [15:0] m_addr,
    output logic [1:0]  m_chan,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  ovf_flag,
    input  logic        ovf_clr,
    output logic [3:0]  link_up,
    output logic [31:0] ovf_cnt
);

    localparam int               c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);

    logic [3:0]  w_nonempty;
    logic [3:0]  w_pop;
    logic [3:0]  w_drop;
    logic [27:0] w_head [4];
    logic        w_load;
    logic        w_found;
    logic [1:0]  w_sel;
    logic [1:0]  w_idx;

    logic        r_m_valid;
    logic [27:0] r_m_word;
    logic [1:0]  r_m_chan;
    logic [1:0]  r_last_grant;
    logic [3:0]  r_ovf_flag;
    logic [3:0]  r_link_up;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_chan
            logic [15:0]        r_addr;
            logic [27:0]        r_mem [FIFO_DEPTH];
            logic [c_ptr_w-1:0] r_wptr;
            logic [c_ptr_w-1:0] r_rptr;
            logic [c_ptr_w:0]   r_cnt;
            logic               w_push_req;
            logic               w_push;
            logic [15:0]        w_addr;

            // A same-cycle address strobe tags the word with the new address
            assign w_addr       = RxAddValid[i] ? RxAdd[16*i +: 16] : r_addr;
            // A channel without link neither queues nor counts drops
            assign w_push_req   = RxValid[i] && !Out_Off_Link[i];
            assign w_push       = w_push_req && ((r_cnt < c_depth) || w_pop[i]);
            assign w_drop[i]    = w_push_req && !w_push;
            // A channel being flushed is not offered to the arbiter
            assign w_nonempty[i] = (r_cnt != '0) && !Out_Off_Link[i];
            assign w_head[i]    = r_mem[r_rptr];

            // Latch the channel address on its strobe
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_addr <= '0;
                end else if (RxAddValid[i]) begin
                    r_addr <= RxAdd[16*i +: 16];
                end
            end

            // FIFO storage, written at the write pointer on an accepted push
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int k = 0; k < FIFO_DEPTH; k++) begin
                        r_mem[k] <= '0;
                    end
                end else if (w_push) begin
                    r_mem[r_wptr] <= {w_addr, RxData[12*i +: 12]};
                end
            end

            // Pointers and occupancy; link loss empties the FIFO
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_cnt  <= '0;
                end else if (Out_Off_Link[i]) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_cnt  <= '0;
                end else begin
                    if (w_push) begin
                        r_wptr <= r_wptr + 1'b1;
                    end
                    if (w_pop[i]) begin
                        r_rptr <= r_rptr + 1'b1;
                    end
                    if (w_push && !w_pop[i]) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (!w_push && w_pop[i]) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Round-robin pick: first non-empty channel after the last grant
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last_grant;
        w_idx   = r_last_grant;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last_grant + k[1:0];
            if (!w_found && w_nonempty[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_load = !r_m_valid || m_ready;
    assign w_pop  = (w_load && w_found) ? (4'b0001 << w_sel) : 4'b0000;

    // Output register slice; contents only change when the slot frees up
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m_valid    <= 1'b0;
            r_m_word     <= '0;
            r_m_chan     <= '0;
            r_last_grant <= 2'd3;
        end else if (w_load) begin
            r_m_valid <= w_found;
            if (w_found) begin
                r_m_word     <= w_head[w_sel];
                r_m_chan     <= w_sel;
                r_last_grant <= w_sel;
            end
        end
    end

    // Sticky drop flags; a drop in the clearing cycle keeps the flag set
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf_flag <= '0;
        end else begin
            r_ovf_flag <= (r_ovf_flag & ~{4{ovf_clr}}) | w_drop;
        end
    end

    // Registered link status
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_link_up <= '0;
        end else begin
            r_link_up <= ~Out_Off_Link;
        end
    end

`ifdef RXM_OVF_CNT_EN
    generate
        for (genvar i = 0; i < 4; i++) begin : g_ovf_cnt
            logic [7:0] r_cnt8;

            // Saturating drop counter; a drop in the clearing cycle counts as 1
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_cnt8 <= '0;
                end else if (ovf_clr) begin
                    r_cnt8 <= {7'd0, w_drop[i]};
                end else if (w_drop[i] && (r_cnt8 != 8'hFF)) begin
                    r_cnt8 <= r_cnt8 + 8'd1;
                end
            end

            assign ovf_cnt[8*i +: 8] = r_cnt8;
        end
    endgenerate
`else
    assign ovf_cnt = '0;
`endif

    assign m_valid  = r_m_valid;
    assign m_addr   = r_m_word[27:12];
    assign m_data   = r_m_word[11:0];
    assign m_chan   = r_m_chan;
    assign ovf_flag = r_ovf_flag;
    assign link_up  = r_link_up;

endmodule
`default_nettype wire
